// File: rtl/fft_amp_capture.sv
// Ping-pong spectrum frame capture with running peak search and random-access readback; optional PEAK_SKIP_DC_EN excludes bin 0 from the peak.
// Latency: last bin written at t -> frame_valid/peak at t+2; rd_en at t -> rd_data/rd_valid at t+1.
// Backpressure: none on the producer; an uncommittable frame is dropped with an overrun pulse, an address gap aborts with seq_err.
module fft_amp_capture #(
    parameter int SQRT_W    = 8,
    parameter int FRAME_LEN = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SQRT_W-1:0] amp_in,
    input  logic [8:0]        amp_addr,
    input  logic              amp_en,
    output logic              frame_valid,
    input  logic              frame_ack,
    input  logic              rd_en,
    input  logic [8:0]        rd_addr,
    output logic [SQRT_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [SQRT_W-1:0] peak_val,
    output logic [8:0]        peak_idx,
    output logic              overrun,
    output logic              seq_err
);

    localparam logic [8:0] LAST_BIN = 9'(FRAME_LEN - 1);
    localparam logic [9:0] FLEN10   = 10'(FRAME_LEN);

    typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT} state_t;

    state_t            state_q, state_d;
    logic              cap_bank_q;
    logic [8:0]        exp_q, exp_d;
    logic [SQRT_W-1:0] run_peak_q, run_peak_d;
    logic [8:0]        run_idx_q, run_idx_d;
    logic              wr_en;
    logic              swap;
    logic              frame_valid_d;
    logic              overrun_d;
    logic              seq_err_d;

    logic [SQRT_W-1:0] mem [0:1][0:511];

    always_comb begin
        state_d       = state_q;
        exp_d         = exp_q;
        run_peak_d    = run_peak_q;
        run_idx_d     = run_idx_q;
        wr_en         = 1'b0;
        swap          = 1'b0;
        overrun_d     = 1'b0;
        seq_err_d     = 1'b0;
        frame_valid_d = frame_valid;
        if (frame_ack) begin
            frame_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (amp_en && amp_addr == 9'd0) begin
                    wr_en     = 1'b1;
                    exp_d     = 9'd1;
                    run_idx_d = 9'd0;
`ifdef PEAK_SKIP_DC_EN
                    run_peak_d = '0;
`else
                    run_peak_d = amp_in;
`endif
                    state_d = (LAST_BIN == 9'd0) ? COMMIT : CAPTURE;
                end
            end
            CAPTURE: begin
                if (amp_en) begin
                    if (amp_addr == exp_q) begin
                        wr_en = 1'b1;
                        exp_d = exp_q + 9'd1;
                        // strict compare keeps the lowest bin on ties
                        if (amp_in > run_peak_q) begin
                            run_peak_d = amp_in;
                            run_idx_d  = amp_addr;
                        end
                        if (amp_addr == LAST_BIN) begin
                            state_d = COMMIT;
                        end
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (!frame_valid || frame_ack) begin
                    swap          = 1'b1;
                    frame_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // bank storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[cap_bank_q][amp_addr] <= amp_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cap_bank_q  <= 1'b0;
            exp_q       <= 9'd0;
            run_peak_q  <= '0;
            run_idx_q   <= 9'd0;
            frame_valid <= 1'b0;
            peak_val    <= '0;
            peak_idx    <= 9'd0;
            overrun     <= 1'b0;
            seq_err     <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            run_peak_q  <= run_peak_d;
            run_idx_q   <= run_idx_d;
            frame_valid <= frame_valid_d;
            overrun     <= overrun_d;
            seq_err     <= seq_err_d;
            rd_valid    <= rd_en;
            if (swap) begin
                cap_bank_q <= ~cap_bank_q;
                peak_val   <= run_peak_q;
                peak_idx   <= run_idx_q;
            end
            if (rd_en) begin
                if ({1'b0, rd_addr} >= FLEN10) begin
                    rd_data <= '0;
                end else begin
                    rd_data <= mem[~cap_bank_q][rd_addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_amp_capture.sv
// Self-checking bench for fft_amp_capture: constant read table plus frame-level reference model.
module tb_fft_amp_capture;

    localparam int W  = 8;
    localparam int FL = 256;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] amp_in;
    logic [8:0]   amp_addr;
    logic         amp_en;
    logic         frame_valid;
    logic         frame_ack;
    logic         rd_en;
    logic [8:0]   rd_addr;
    logic [W-1:0] rd_data;
    logic         rd_valid;
    logic [W-1:0] peak_val;
    logic [8:0]   peak_idx;
    logic         overrun;
    logic         seq_err;

    fft_amp_capture #(.SQRT_W(W), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst),
        .amp_in(amp_in), .amp_addr(amp_addr), .amp_en(amp_en),
        .frame_valid(frame_valid), .frame_ack(frame_ack),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .peak_val(peak_val), .peak_idx(peak_idx),
        .overrun(overrun), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    addr;
        int    exp;
        string name;
    } rd_vec_t;

    int n_checks = 0;
    int n_errors = 0;
    int fbuf    [512];
    int mdl_mem [512];
    int mdl_valid;
    int mdl_pk;
    int mdl_ix;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int v);
        amp_en   = 1'b1;
        amp_addr = a[8:0];
        amp_in   = v[7:0];
        tick();
        amp_en   = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < FL; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 3) == 0) tick();
            send(i, fbuf[i]);
        end
    endtask

    task automatic rand_frame(input int maxv);
        for (int i = 0; i < FL; i++) fbuf[i] = $urandom_range(0, maxv);
    endtask

    // Peak = maximum over the searched bins, reported at the first bin holding it.
    function automatic void model_peak(output int pk, output int ix);
        int lo;
`ifdef PEAK_SKIP_DC_EN
        lo = 1;
`else
        lo = 0;
`endif
        pk = 0;
        for (int i = lo; i < FL; i++) if (fbuf[i] > pk) pk = fbuf[i];
        ix = 0;
        if (pk != 0) begin
            for (int i = FL - 1; i >= lo; i--) if (fbuf[i] == pk) ix = i;
        end
    endfunction

    // Entered in the COMMIT cycle (one cycle after the last bin write).
    task automatic commit_phase(input bit ack, input string tag);
        bit will_swap;
        will_swap = (mdl_valid == 0) || ack;
        check({tag, "_fv_t1"}, frame_valid, mdl_valid);
        check({tag, "_pk_t1"}, peak_val, mdl_pk);
        frame_ack = ack;
        tick();
        frame_ack = 1'b0;
        if (will_swap) begin
            for (int i = 0; i < 512; i++) mdl_mem[i] = fbuf[i];
            model_peak(mdl_pk, mdl_ix);
            mdl_valid = 1;
        end
        check({tag, "_fv_t2"}, frame_valid, mdl_valid);
        check({tag, "_peak_val"}, peak_val, mdl_pk);
        check({tag, "_peak_idx"}, peak_idx, mdl_ix);
        check({tag, "_overrun"}, overrun, !will_swap);
        tick();
        check({tag, "_overrun_clr"}, overrun, 0);
    endtask

    task automatic do_read(input int a, input int exp, input string name);
        rd_en   = 1'b1;
        rd_addr = a[8:0];
        tick();
        rd_en   = 1'b0;
        check({name, "_rd_valid"}, rd_valid, 1);
        check({name, "_rd_data"}, rd_data, exp);
        tick();
        check({name, "_rd_valid_clr"}, rd_valid, 0);
    endtask

    task automatic rand_reads(input int n, input string name);
        int a;
        for (int k = 0; k < n; k++) begin
            a = $urandom_range(0, 511);
            do_read(a, (a < FL) ? mdl_mem[a] : 0, name);
        end
    endtask

    task automatic ack_release();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        mdl_valid = 0;
        check("ack_release_fv", frame_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_frame_valid"}, frame_valid, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_peak_val"}, peak_val, 0);
        check({tag, "_peak_idx"}, peak_idx, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_seq_err"}, seq_err, 0);
    endtask

    initial begin
        rd_vec_t tbl [8];
        int exp_pk;
        int exp_ix;
        tbl[0] = '{37, 37, "tbl_b37"};
        tbl[1] = '{199, 199, "tbl_b199"};
        tbl[2] = '{200, 0, "tbl_b200"};
        tbl[3] = '{255, 55, "tbl_b255"};
        tbl[4] = '{0, 0, "tbl_b0"};
        tbl[5] = '{150, 150, "tbl_b150"};
        tbl[6] = '{256, 0, "tbl_oor256"};
        tbl[7] = '{511, 0, "tbl_oor511"};

        rst = 1'b1; amp_in = '0; amp_addr = '0; amp_en = 1'b0;
        frame_ack = 1'b0; rd_en = 1'b0; rd_addr = '0;
        mdl_valid = 0; mdl_pk = 0; mdl_ix = 0;
        for (int i = 0; i < 512; i++) mdl_mem[i] = 0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // capture must not start on anything but bin 0
        send(5, 1);
        send(6, 2);
        tick();
        check("stray_seq_err", seq_err, 0);
        check("stray_fv", frame_valid, 0);

        // frame A: amp = bin % 200
        for (int i = 0; i < FL; i++) fbuf[i] = i % 200;
        send_frame(1'b0);
        commit_phase(1'b0, "A");
        check("A_peak_val_const", peak_val, 199);
        check("A_peak_idx_const", peak_idx, 199);
        for (int i = 0; i < 8; i++) do_read(tbl[i].addr, tbl[i].exp, tbl[i].name);

        // frame B dropped: valid frame held, no ack
        rand_frame(255);
        send_frame(1'b1);
        commit_phase(1'b0, "B");
        do_read(37, 37, "B_keep37");
        check("B_peak_const", peak_val, 199);

        // frame C: ack in the commit cycle swaps and keeps frame_valid
        rand_frame(15);
        send_frame(1'b1);
        commit_phase(1'b1, "C");
        rand_reads(6, "C");

        ack_release();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        check("ack_idle_fv", frame_valid, 0);
        rand_reads(2, "released");

        // address gap aborts; trailing bins must not resume the stream
        for (int i = 0; i < 100; i++) send(i, 3);
        send(150, 7);
        check("gap_seq_err", seq_err, 1);
        tick();
        check("gap_seq_err_clr", seq_err, 0);
        for (int i = 100; i < FL; i++) send(i, 9);
        tick();
        tick();
        check("gap_no_commit_fv", frame_valid, 0);
        check("gap_no_overrun", overrun, 0);
        do_read(50, mdl_mem[50], "gap_keep50");
        rand_frame(255);
        send_frame(1'b1);
        commit_phase(1'b0, "D");
        rand_reads(3, "D");

        // DC bin dominance
        rand_frame(9);
        fbuf[0]  = 255;
        fbuf[9]  = 10;
        fbuf[77] = 10;
        send_frame(1'b0);
        commit_phase(1'b1, "E");
`ifdef PEAK_SKIP_DC_EN
        exp_pk = 10;  exp_ix = 9;
`else
        exp_pk = 255; exp_ix = 0;
`endif
        check("E_peak_val_const", peak_val, exp_pk);
        check("E_peak_idx_const", peak_idx, exp_ix);
        do_read(0, 255, "E_bin0");

        // reset mid-capture
        rand_frame(255);
        for (int i = 0; i < 120; i++) send(i, fbuf[i]);
        rst = 1'b1;
        #2;
        check_reset_outputs("midrst");
        tick();
        check_reset_outputs("midrst_held");
        rst = 1'b0;
        mdl_valid = 0; mdl_pk = 0; mdl_ix = 0;
        tick();
        for (int i = 120; i < 131; i++) send(i, 1);
        tick();
        check("midrst_no_resume_fv", frame_valid, 0);
        send_frame(1'b1);
        commit_phase(1'b0, "F");
        rand_reads(4, "F");

        // randomized frames with random ack policy
        for (int f = 0; f < 6; f++) begin
            if (mdl_valid != 0 && $urandom_range(0, 1) == 1) ack_release();
            for (int s = 0; s < int'($urandom_range(0, 3)); s++) send($urandom_range(1, 255), 5);
            rand_frame(($urandom_range(0, 1) == 1) ? 15 : 255);
            send_frame(1'b1);
            commit_phase(1'($urandom_range(0, 1)), "R");
            rand_reads(4, "R");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
